// File: rtl/adventure_pkg.sv
// Shared definitions for the adventure game: room codes, the controller
// phase encoding and a small one-hot helper used by the front-end controller.
package adventure_pkg;

  typedef enum logic [2:0] {
    ROOM_CAVE_ENTRANCE      = 3'b000,
    ROOM_TWISTY_TUNNEL      = 3'b001,
    ROOM_RAPID_RIVER        = 3'b010,
    ROOM_SECRET_SWORD       = 3'b011,
    ROOM_DRAGON_DEN         = 3'b100,
    ROOM_VICTORY_VAULT      = 3'b101,
    ROOM_GRIEVOUS_GRAVEYARD = 3'b110
  } room_t;

  localparam logic [2:0] SWORD_ROOM = 3'(ROOM_SECRET_SWORD);

  typedef enum logic [1:0] {
    PH_PLAY         = 2'd0,
    PH_WAIT_RELEASE = 2'd1,
    PH_END_HOLD     = 2'd2,
    PH_RESTART      = 2'd3
  } ctrl_phase_t;

  // True when exactly one bit of the button vector is set.
  function automatic logic is_one_hot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/adventure_ctrl_debouncer.sv
// Two-flop synchronizer followed by a vector stability counter. The
// debounced vector only changes once the synchronized vector has held the
// same value for DEBOUNCE_CYCLES consecutive samples.
module button_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] sync_prev;
  logic [CNT_W-1:0] same_cnt;
  logic [CNT_W-1:0] same_cnt_next;

  // Length of the current run of identical samples, including this one.
  always_comb begin
    same_cnt_next = same_cnt;
    if (sync_out != sync_prev) begin
      same_cnt_next = CNT_W'(1);
    end else if (same_cnt < CNT_TARGET) begin
      same_cnt_next = same_cnt + CNT_W'(1);
    end
  end

  // Synchronize the raw buttons and commit the vector once the run is long enough.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_out  <= '0;
      sync_prev <= '0;
      same_cnt  <= '0;
      stable    <= '0;
    end else begin
      sync_meta <= raw;
      sync_out  <= sync_meta;
      sync_prev <= sync_out;
      same_cnt  <= same_cnt_next;
      if (same_cnt_next == CNT_TARGET) begin
        stable <= sync_out;
      end
    end
  end

endmodule

// File: rtl/adventure_ctrl.sv
// Front-end controller for the room FSM: turns debounced button presses into
// single-cycle direction pulses, tracks the sword and the move count, and
// sequences the hold-then-restart at end of game.
module adventure_ctrl
  import adventure_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int END_HOLD_CYCLES = 16,
  parameter int MOVE_CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            btn,
  input  logic [2:0]            curr_room,
  input  logic                  win,
  input  logic                  die,
  output logic                  dir_n,
  output logic                  dir_s,
  output logic                  dir_e,
  output logic                  dir_w,
  output logic                  has_sword,
  output logic                  game_reset,
  output logic [MOVE_CNT_W-1:0] move_count,
  output logic [1:0]            phase
);

  localparam int HOLD_W = (END_HOLD_CYCLES > 1) ? $clog2(END_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(END_HOLD_CYCLES - 1);

  localparam logic [1:0] PLAY         = 2'(PH_PLAY);
  localparam logic [1:0] WAIT_RELEASE = 2'(PH_WAIT_RELEASE);
  localparam logic [1:0] END_HOLD     = 2'(PH_END_HOLD);
  localparam logic [1:0] RESTART      = 2'(PH_RESTART);

  logic [3:0]        stable;
  logic [3:0]        prev_stable;
  logic [HOLD_W-1:0] hold_cnt;
  logic              press_rise;
  logic              press_single;
  logic              end_req;
  logic              live_phase;

  button_debouncer #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .reset  (reset),
    .raw    (btn),
    .stable (stable)
  );

  assign press_rise   = (prev_stable == 4'b0000) && (stable != 4'b0000);
  assign press_single = is_one_hot4(stable);
  assign end_req      = win | die;
  assign live_phase   = (phase == PLAY) || (phase == WAIT_RELEASE);

  // Phase FSM, direction pulses, inventory, move counter and end-of-game timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase       <= PLAY;
      prev_stable <= 4'b0000;
      hold_cnt    <= '0;
      dir_n       <= 1'b0;
      dir_s       <= 1'b0;
      dir_e       <= 1'b0;
      dir_w       <= 1'b0;
      has_sword   <= 1'b0;
      game_reset  <= 1'b0;
      move_count  <= '0;
    end else begin
      prev_stable <= stable;
      dir_n       <= 1'b0;
      dir_s       <= 1'b0;
      dir_e       <= 1'b0;
      dir_w       <= 1'b0;
      game_reset  <= 1'b0;

      if (live_phase && (curr_room == SWORD_ROOM)) begin
        has_sword <= 1'b1;
      end

      case (phase)
        PLAY: begin
          if (end_req) begin
            phase    <= END_HOLD;
            hold_cnt <= HOLD_INIT;
          end else if (press_rise) begin
            // Chords still need a release before the next move is accepted.
            phase <= WAIT_RELEASE;
            if (press_single) begin
              {dir_n, dir_s, dir_e, dir_w} <= stable;
              if (move_count != {MOVE_CNT_W{1'b1}}) begin
                move_count <= move_count + MOVE_CNT_W'(1);
              end
            end
          end
        end
        WAIT_RELEASE: begin
          if (end_req) begin
            phase    <= END_HOLD;
            hold_cnt <= HOLD_INIT;
          end else if (stable == 4'b0000) begin
            phase <= PLAY;
          end
        end
        END_HOLD: begin
          if (hold_cnt == '0) begin
            phase      <= RESTART;
            game_reset <= 1'b1;
            has_sword  <= 1'b0;
            move_count <= '0;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        default: begin
          // A button still held across the restart must not count as a move.
          phase <= WAIT_RELEASE;
        end
      endcase
    end
  end

endmodule

// File: doc/adventure_ctrl.md
# adventure_ctrl

Front-end controller for the adventure game's room state machine. It synchronizes and debounces the four raw direction buttons and turns each clean single-button press into exactly one single-cycle direction pulse. It also owns the sword-inventory flag, and it sequences end-of-game: it holds on WIN/DIE, then issues a one-cycle game restart. It sits between the board pushbuttons and the room FSM, whose N/S/E/W and has_sword inputs it drives.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical synchronized samples required before the debounced button vector updates (≥1).
- END_HOLD_CYCLES, 16: cycles spent in END_HOLD before restart (≥1).
- MOVE_CNT_W, 8: width of move_count.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- btn  in  4  raw asynchronous buttons, {N,S,E,W} = btn[3:0].
- curr_room  in  3  room code from the room FSM.
- win  in  1  room FSM WIN.
- die  in  1  room FSM DIE.
- dir_n, dir_s, dir_e, dir_w  out  1 each  registered single-cycle move pulses.
- has_sword  out  1  registered inventory flag.
- game_reset  out  1  registered one-cycle restart pulse; top level ORs it with reset into the room FSM reset.
- move_count  out  MOVE_CNT_W  accepted moves since last restart, saturating.
- phase  out  2  controller state: PLAY=0, WAIT_RELEASE=1, END_HOLD=2, RESTART=3.

## Operation

- **Conditioning:** btn passes through a two-flop synchronizer, then a vector debouncer. The debounced register `stable` loads the synchronized vector once that vector has been unchanged for DEBOUNCE_CYCLES consecutive cycles. Any change in the vector restarts the count.
- **PLAY:**
  - On a cycle where `stable` goes from 0000 to a one-hot value: pulse the matching dir_* output, increment move_count (saturating at all-ones), and go to WAIT_RELEASE.
  - On a transition from 0000 to a multi-hot value: no pulse, no count, go to WAIT_RELEASE.
- **WAIT_RELEASE:** stay until `stable` == 0000, then go to PLAY. No pulses are generated in this state.
- **End of game:** from PLAY or WAIT_RELEASE, if win or die is sampled high, go to END_HOLD and load hold_cnt = END_HOLD_CYCLES-1.
  - win/die take priority over a press detected in the same cycle; that press produces no pulse.
- **END_HOLD:** decrement hold_cnt each cycle. When it reaches 0, go to RESTART. Button activity is ignored.
- **RESTART:** lasts one cycle. game_reset=1, has_sword cleared, move_count cleared. Next state is WAIT_RELEASE, so a button still held does not move the player.
- **has_sword:**
  - Set when curr_room == SWORD_ROOM (3'b011) in PLAY or WAIT_RELEASE.
  - Sticky until reset or RESTART.
  - Never set during END_HOLD or RESTART.
- **Mid-operation reset:** asynchronously forces all registers to their reset values, regardless of phase.
- **Reset values:** dir_*=0, has_sword=0, game_reset=0, move_count=0, phase=PLAY, `stable`=0000, synchronizer and debounce counter=0, hold_cnt=0.
- **Pulse invariant:** at most one dir_* output is high in any cycle.

## Timing

- Let t0 be the first clk edge that samples a new raw btn value, with btn held stable afterwards. `stable` updates at edge t0+1+DEBOUNCE_CYCLES, and the dir pulse is high for the one cycle after edge t0+2+DEBOUNCE_CYCLES. With defaults, that is edge t0+6.
- move_count increments at the same edge the dir pulse rises.
- If win is first sampled high at edge t:
  - phase=END_HOLD after edge t;
  - game_reset is high for the cycle after edge t+END_HOLD_CYCLES;
  - phase=WAIT_RELEASE after edge t+END_HOLD_CYCLES+1.
- has_sword rises one cycle after curr_room first shows SWORD_ROOM.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure

- **Shared package adventure_pkg** contains:
  - the room enum (the room FSM imports it instead of keeping a local typedef);
  - SWORD_ROOM;
  - the ctrl_phase_t enum.
- **Sub-module button_debouncer** (parameter WIDTH, DEBOUNCE_CYCLES) contains the synchronizer plus the vector stability counter, and outputs `stable`. adventure_ctrl instantiates it once with WIDTH=4.
- **adventure_ctrl itself** holds:
  - the phase FSM;
  - edge detection on `stable` (previous-value register);
  - hold_cnt, move_count and the has_sword flag.

## Test plan

- Reset, then hold btn=0010 (E) for 10 cycles → dir_e high for exactly one cycle, 6 edges after the first sample; move_count=1; phase=WAIT_RELEASE until release.
- btn toggles every 2 cycles for 20 cycles, then settles at 0000 → no dir pulse; move_count=0.
- btn=1010 (N+E) pressed together → no pulse; move_count=0; after release and a new E press, exactly one dir_e pulse.
- curr_room driven 3'b011 for one cycle → has_sword=1 next cycle and stays 1 after curr_room changes.
- From that state, win asserted at edge t → phase=2, game_reset high only in the cycle after edge t+16, then has_sword=0, move_count=0, phase=1.
- Assert die together with an E press detected in the same cycle → no dir_e pulse. Then assert reset mid-END_HOLD → all outputs at reset values immediately, and phase=PLAY.
